rob_ctrl: RTL and testbench

ROB_CTRL -- requirements
Module: rob_ctrl

---
 rtl/data_structures.sv | 41 ++++
 rtl/rob_ctrl.sv | 158 +++++++++++++++
 tb/tb_rob_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_structures.sv
// ----------------------------------------------------------------------------
// Shared sizing macros and types for the reorder-buffer controller.
//   `ROB_SIZE      : number of ROB entries (power of two)
//   `ROB_IDX_SIZE  : log2(`ROB_SIZE), width of an entry index
//   `GPR_IDX_SIZE  : width of a general-purpose register index
// The package mirrors the macros as typed localparams and carries the FSM
// state enum and the per-entry record.
// ----------------------------------------------------------------------------
`ifndef ROB_SIZE
`define ROB_SIZE 8
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 3
`endif
`ifndef GPR_IDX_SIZE
`define GPR_IDX_SIZE 5
`endif

package rob_ctrl_pkg;

  localparam int ROB_SIZE     = `ROB_SIZE;
  localparam int ROB_IDX_SIZE = `ROB_IDX_SIZE;
  localparam int GPR_IDX_SIZE = `GPR_IDX_SIZE;

  // Occupancy value meaning "every entry allocated"; count is one bit wider
  // than an index so that full and empty are distinguishable.
  localparam logic [ROB_IDX_SIZE:0] ROB_FULL_COUNT = (ROB_IDX_SIZE+1)'(ROB_SIZE);

  typedef enum logic {
    ROB_RUN   = 1'b0,
    ROB_FLUSH = 1'b1
  } rob_state_e;

  typedef struct packed {
    logic                    busy;
    logic                    done;
    logic [GPR_IDX_SIZE-1:0] gpr_idx;
    logic                    writes_gpr;
  } rob_ctrl_entry_t;

endpackage

// File: rtl/rob_ctrl.sv
// ----------------------------------------------------------------------------
// rob_ctrl : in-order reorder-buffer controller (circular buffer of entries).
// Ports
//   in_clk, in_rst (sync, active-low)
//   in_alloc_req / in_alloc_gpr_idx / in_alloc_writes_gpr -> out_alloc_ok,
//     out_alloc_idx (always the tail)
//   in_done / in_done_idx           : FU completion for one entry
//   in_mispred / in_mispred_idx     : branch mispredict, squashes younger ops
//   in_commit_ready                 : regfile accepts a retirement
//   out_commit_valid / out_commit_idx / out_commit_gpr_idx /
//     out_commit_writes_gpr         : head entry, ready to retire
//   out_full, out_empty, out_count  : occupancy
//   out_flush                       : one-cycle squash pulse after a mispredict
// ----------------------------------------------------------------------------
module rob_ctrl
  import rob_ctrl_pkg::*;
(
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic                    in_alloc_req,
  input  logic [GPR_IDX_SIZE-1:0] in_alloc_gpr_idx,
  input  logic                    in_alloc_writes_gpr,
  output logic                    out_alloc_ok,
  output logic [ROB_IDX_SIZE-1:0] out_alloc_idx,
  input  logic                    in_done,
  input  logic [ROB_IDX_SIZE-1:0] in_done_idx,
  input  logic                    in_mispred,
  input  logic [ROB_IDX_SIZE-1:0] in_mispred_idx,
  input  logic                    in_commit_ready,
  output logic                    out_commit_valid,
  output logic [ROB_IDX_SIZE-1:0] out_commit_idx,
  output logic [GPR_IDX_SIZE-1:0] out_commit_gpr_idx,
  output logic                    out_commit_writes_gpr,
  output logic                    out_full,
  output logic                    out_empty,
  output logic [ROB_IDX_SIZE:0]   out_count,
  output logic                    out_flush
);

  localparam logic [ROB_IDX_SIZE-1:0] IDX_ONE = ROB_IDX_SIZE'(1);
  localparam logic [ROB_IDX_SIZE:0]   CNT_ONE = (ROB_IDX_SIZE+1)'(1);

  // Age of an entry relative to the head: 0 = oldest. Index width is a power
  // of two, so plain wrap-around subtraction gives the modulo distance.
  function automatic logic [ROB_IDX_SIZE-1:0] age(
    input logic [ROB_IDX_SIZE-1:0] idx,
    input logic [ROB_IDX_SIZE-1:0] head
  );
    return idx - head;
  endfunction

  rob_state_e              state_q;
  logic [ROB_IDX_SIZE-1:0] head_q;
  logic [ROB_IDX_SIZE-1:0] tail_q;
  logic [ROB_IDX_SIZE:0]   count_q;

  rob_ctrl_entry_t         entry_arr [ROB_SIZE];

  logic                    commit_fire;
  logic                    mispred_acc;
  logic [ROB_IDX_SIZE-1:0] mispred_age;
  logic [ROB_IDX_SIZE:0]   alloc_inc;
  logic [ROB_IDX_SIZE:0]   commit_dec;

  // Allocation looks at the raw mispredict (not the accepted one) and at the
  // registered count only, so a slot freed by this cycle's commit is not reused.
  assign out_alloc_ok = in_alloc_req && (count_q < ROB_FULL_COUNT) &&
                        (state_q == ROB_RUN) && !in_mispred;

  assign out_commit_valid = entry_arr[head_q].busy && entry_arr[head_q].done;
  assign commit_fire      = out_commit_valid && in_commit_ready;

  assign mispred_acc = in_mispred && (state_q == ROB_RUN) && entry_arr[in_mispred_idx].busy;
  assign mispred_age = age(in_mispred_idx, head_q);

  assign alloc_inc  = {{ROB_IDX_SIZE{1'b0}}, out_alloc_ok};
  assign commit_dec = {{ROB_IDX_SIZE{1'b0}}, commit_fire};

  // Per-entry state
  for (genvar gi = 0; gi < ROB_SIZE; gi++) begin : g_entry
    localparam logic [ROB_IDX_SIZE-1:0] EIDX = ROB_IDX_SIZE'(gi);

    rob_ctrl_entry_t entry_q;
    rob_ctrl_entry_t entry_d;
    logic            squash;

    // Strictly younger than the mispredicted branch: the branch itself stays.
    assign squash = mispred_acc && (age(EIDX, head_q) > mispred_age);

    always_comb begin
      entry_d = entry_q;
      if (in_done && (in_done_idx == EIDX) && entry_q.busy && !squash) begin
        entry_d.done = 1'b1;
      end
      if (commit_fire && (head_q == EIDX)) begin
        entry_d.busy = 1'b0;
      end
      if (squash) begin
        entry_d.busy = 1'b0;
        entry_d.done = 1'b0;
      end
      if (out_alloc_ok && (tail_q == EIDX)) begin
        entry_d.busy       = 1'b1;
        entry_d.done       = 1'b0;
        entry_d.gpr_idx    = in_alloc_gpr_idx;
        entry_d.writes_gpr = in_alloc_writes_gpr;
      end
    end

    always_ff @(posedge in_clk) begin
      if (!in_rst) begin
        entry_q.busy <= 1'b0;
        entry_q.done <= 1'b0;
      end else begin
        entry_q <= entry_d;
      end
    end

    assign entry_arr[gi] = entry_q;
  end

  // Control FSM plus head/tail/count pointers
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      state_q <= ROB_RUN;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= ((state_q == ROB_RUN) && mispred_acc) ? ROB_FLUSH : ROB_RUN;

      if (commit_fire) begin
        head_q <= head_q + IDX_ONE;
      end

      if (mispred_acc) begin
        // Survivors are the head through the branch, minus a same-cycle commit.
        tail_q  <= in_mispred_idx + IDX_ONE;
        count_q <= {1'b0, mispred_age} + CNT_ONE - commit_dec;
      end else begin
        if (out_alloc_ok) begin
          tail_q <= tail_q + IDX_ONE;
        end
        count_q <= count_q + alloc_inc - commit_dec;
      end
    end
  end

  assign out_alloc_idx         = tail_q;
  assign out_commit_idx        = head_q;
  assign out_commit_gpr_idx    = entry_arr[head_q].gpr_idx;
  assign out_commit_writes_gpr = entry_arr[head_q].writes_gpr;
  assign out_full              = (count_q == ROB_FULL_COUNT);
  assign out_empty             = (count_q == '0);
  assign out_count             = count_q;
  assign out_flush             = (state_q == ROB_FLUSH);

endmodule

// File: tb/tb_rob_ctrl.sv
// ----------------------------------------------------------------------------
// Self-checking bench for rob_ctrl. A queue-based model (entries in age order,
// plus a head pointer and a flush flag) tracks what the ROB should hold.
// Directed scenarios compare against hand-derived constants; the random
// scenario compares every cycle against the model.
// ----------------------------------------------------------------------------
module tb_rob_ctrl;
  import rob_ctrl_pkg::*;

  localparam int N = ROB_SIZE;

  logic                    clk = 1'b0;
  logic                    in_rst;
  logic                    in_alloc_req;
  logic [GPR_IDX_SIZE-1:0] in_alloc_gpr_idx;
  logic                    in_alloc_writes_gpr;
  logic                    out_alloc_ok;
  logic [ROB_IDX_SIZE-1:0] out_alloc_idx;
  logic                    in_done;
  logic [ROB_IDX_SIZE-1:0] in_done_idx;
  logic                    in_mispred;
  logic [ROB_IDX_SIZE-1:0] in_mispred_idx;
  logic                    in_commit_ready;
  logic                    out_commit_valid;
  logic [ROB_IDX_SIZE-1:0] out_commit_idx;
  logic [GPR_IDX_SIZE-1:0] out_commit_gpr_idx;
  logic                    out_commit_writes_gpr;
  logic                    out_full;
  logic                    out_empty;
  logic [ROB_IDX_SIZE:0]   out_count;
  logic                    out_flush;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  rob_ctrl dut (
    .in_clk               (clk),
    .in_rst               (in_rst),
    .in_alloc_req         (in_alloc_req),
    .in_alloc_gpr_idx     (in_alloc_gpr_idx),
    .in_alloc_writes_gpr  (in_alloc_writes_gpr),
    .out_alloc_ok         (out_alloc_ok),
    .out_alloc_idx        (out_alloc_idx),
    .in_done              (in_done),
    .in_done_idx          (in_done_idx),
    .in_mispred           (in_mispred),
    .in_mispred_idx       (in_mispred_idx),
    .in_commit_ready      (in_commit_ready),
    .out_commit_valid     (out_commit_valid),
    .out_commit_idx       (out_commit_idx),
    .out_commit_gpr_idx   (out_commit_gpr_idx),
    .out_commit_writes_gpr(out_commit_writes_gpr),
    .out_full             (out_full),
    .out_empty            (out_empty),
    .out_count            (out_count),
    .out_flush            (out_flush)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [GPR_IDX_SIZE-1:0] gpr;
    bit                      wr;
    bit                      done;
  } m_ent_t;

  m_ent_t mq[$];      // mq[0] is the oldest entry, at index m_head
  int     m_head = 0;
  bit     m_flush = 0;

  function automatic int wrap(input int v);
    return ((v % N) + N) % N;
  endfunction

  function automatic bit m_alloc_ok();
    return in_alloc_req && (mq.size() < N) && !m_flush && !in_mispred;
  endfunction

  function automatic bit m_commit_valid();
    return (mq.size() > 0) && mq[0].done;
  endfunction

  // Set inputs, then let combinational outputs settle (sampled mid-cycle).
  task automatic drive(input int rst, input int areq, input int gpr, input int wr,
                       input int dn, input int didx, input int mp, input int midx,
                       input int rdy);
    in_rst              = rst[0];
    in_alloc_req        = areq[0];
    in_alloc_gpr_idx    = GPR_IDX_SIZE'(gpr);
    in_alloc_writes_gpr = wr[0];
    in_done             = dn[0];
    in_done_idx         = ROB_IDX_SIZE'(didx);
    in_mispred          = mp[0];
    in_mispred_idx      = ROB_IDX_SIZE'(midx);
    in_commit_ready     = rdy[0];
    #2;
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance one clock, updating the model from the inputs presented this cycle.
  task automatic tick();
    bit ok, cf, ma;
    int mp, dp;
    ok = m_alloc_ok();
    cf = m_commit_valid() && in_commit_ready;
    mp = wrap(int'(in_mispred_idx) - m_head);
    dp = wrap(int'(in_done_idx) - m_head);
    ma = in_mispred && !m_flush && (mp < mq.size());
    if (in_done && (dp < mq.size()) && !(ma && dp > mp)) mq[dp].done = 1;
    if (ma) while (mq.size() > mp + 1) void'(mq.pop_back());
    if (cf) begin
      void'(mq.pop_front());
      m_head = wrap(m_head + 1);
    end
    if (ok) mq.push_back('{gpr: in_alloc_gpr_idx, wr: in_alloc_writes_gpr, done: 1'b0});
    m_flush = ma;
    if (!in_rst) begin
      mq.delete();
      m_head  = 0;
      m_flush = 0;
    end
    if (in_rst && (ok || cf || ma))
      $display("tx cyc=%0d alloc=%0d commit=%0d mispred=%0d model_count=%0d", cyc, ok, cf, ma, mq.size());
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    idle();
    checks++; if (out_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", out_empty); end
    checks++; if (out_full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", out_full); end
    checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", out_count); end
    checks++; if (out_commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit_valid got %0b want 0", out_commit_valid); end
    checks++; if (out_flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %0b want 0", out_flush); end
    checks++; if (out_alloc_idx !== 3'd0) begin errors++; $display("FAIL reset_alloc_idx got %0d want 0", out_alloc_idx); end
    $display("test_reset done");
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, i + 10, i % 2, 0, 0, 0, 0, 0);
      checks++; if (out_alloc_ok !== 1'b1) begin errors++; $display("FAIL fill_ok[%0d] got %0b want 1", i, out_alloc_ok); end
      checks++; if (out_alloc_idx !== 3'(i)) begin errors++; $display("FAIL fill_idx[%0d] got %0d want %0d", i, out_alloc_idx, i); end
      tick();
    end
    drive(1, 1, 3, 1, 0, 0, 0, 0, 0);
    checks++; if (out_full !== 1'b1) begin errors++; $display("FAIL fill_full got %0b want 1", out_full); end
    checks++; if (out_count !== 4'd8) begin errors++; $display("FAIL fill_count got %0d want 8", out_count); end
    checks++; if (out_alloc_ok !== 1'b0) begin errors++; $display("FAIL fill_ninth_ok got %0b want 0", out_alloc_ok); end
    tick();
    idle();
    checks++; if (out_count !== 4'd8) begin errors++; $display("FAIL fill_count_after got %0d want 8", out_count); end
    $display("test_fill done");
  endtask

  // Continues from the full ROB left by test_fill (head 0).
  task automatic test_full_wrap();
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0);
    tick();
    drive(1, 1, 21, 1, 0, 0, 0, 0, 1);
    checks++; if (out_commit_valid !== 1'b1) begin errors++; $display("FAIL wrap_commit_valid got %0b want 1", out_commit_valid); end
    checks++; if (out_commit_gpr_idx !== 5'd10) begin errors++; $display("FAIL wrap_commit_gpr got %0d want 10", out_commit_gpr_idx); end
    checks++; if (out_alloc_ok !== 1'b0) begin errors++; $display("FAIL wrap_alloc_while_full got %0b want 0", out_alloc_ok); end
    tick();
    drive(1, 1, 21, 1, 0, 0, 0, 0, 0);
    checks++; if (out_count !== 4'd7) begin errors++; $display("FAIL wrap_count got %0d want 7", out_count); end
    checks++; if (out_alloc_ok !== 1'b1) begin errors++; $display("FAIL wrap_alloc_ok got %0b want 1", out_alloc_ok); end
    checks++; if (out_alloc_idx !== 3'd0) begin errors++; $display("FAIL wrap_alloc_idx got %0d want 0", out_alloc_idx); end
    tick();
    idle();
    checks++; if (out_full !== 1'b1) begin errors++; $display("FAIL wrap_full_again got %0b want 1", out_full); end
    $display("test_full_wrap done");
  endtask

  task automatic test_commit_order();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, i + 1, 1, 0, 0, 0, 0, 0);
      tick();
    end
    drive(1, 0, 0, 0, 1, 2, 0, 0, 1);
    tick();
    drive(1, 0, 0, 0, 1, 0, 0, 0, 1);
    checks++; if (out_commit_valid !== 1'b0) begin errors++; $display("FAIL order_valid_before_done0 got %0b want 0", out_commit_valid); end
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    checks++; if (out_commit_valid !== 1'b1) begin errors++; $display("FAIL order_valid_after_done0 got %0b want 1", out_commit_valid); end
    checks++; if (out_commit_idx !== 3'd0) begin errors++; $display("FAIL order_commit_idx0 got %0d want 0", out_commit_idx); end
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
      checks++; if (out_commit_valid !== 1'b0) begin errors++; $display("FAIL order_idx2_blocked[%0d] got %0b want 0", k, out_commit_valid); end
      tick();
    end
    drive(1, 0, 0, 0, 1, 1, 0, 0, 1);
    checks++; if (out_count !== 4'd2) begin errors++; $display("FAIL order_count got %0d want 2", out_count); end
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    checks++; if (out_commit_idx !== 3'd1 || out_commit_valid !== 1'b1) begin errors++; $display("FAIL order_commit_idx1 got idx=%0d v=%0b want idx=1 v=1", out_commit_idx, out_commit_valid); end
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    checks++; if (out_commit_idx !== 3'd2 || out_commit_gpr_idx !== 5'd3) begin errors++; $display("FAIL order_commit_idx2 got idx=%0d gpr=%0d want idx=2 gpr=3", out_commit_idx, out_commit_gpr_idx); end
    tick();
    idle();
    checks++; if (out_empty !== 1'b1) begin errors++; $display("FAIL order_empty got %0b want 1", out_empty); end
    $display("test_commit_order done");
  endtask

  task automatic test_mispred_flush();
    do_reset();
    // Walk head to 6 by allocating, completing and retiring six entries.
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 0, 0, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 1, i, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, i, 1, 0, 0, 0, 0, 0);
      tick();
    end
    drive(1, 1, 0, 0, 0, 0, 1, 0, 0);
    checks++; if (out_count !== 4'd6) begin errors++; $display("FAIL mp_count_before got %0d want 6", out_count); end
    checks++; if (out_commit_idx !== 3'd6) begin errors++; $display("FAIL mp_head got %0d want 6", out_commit_idx); end
    checks++; if (out_alloc_ok !== 1'b0) begin errors++; $display("FAIL mp_alloc_same_cycle got %0b want 0", out_alloc_ok); end
    tick();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (out_flush !== 1'b1) begin errors++; $display("FAIL mp_flush got %0b want 1", out_flush); end
    checks++; if (out_count !== 4'd3) begin errors++; $display("FAIL mp_count got %0d want 3", out_count); end
    checks++; if (out_alloc_idx !== 3'd1) begin errors++; $display("FAIL mp_tail got %0d want 1", out_alloc_idx); end
    checks++; if (out_alloc_ok !== 1'b0) begin errors++; $display("FAIL mp_alloc_in_flush got %0b want 0", out_alloc_ok); end
    tick();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (out_flush !== 1'b0) begin errors++; $display("FAIL mp_flush_end got %0b want 0", out_flush); end
    checks++; if (out_alloc_ok !== 1'b1 || out_alloc_idx !== 3'd1) begin errors++; $display("FAIL mp_alloc_after got ok=%0b idx=%0d want ok=1 idx=1", out_alloc_ok, out_alloc_idx); end
    tick();
    idle();
    checks++; if (out_count !== 4'd4) begin errors++; $display("FAIL mp_count_after got %0d want 4", out_count); end
    $display("test_mispred_flush done");
  endtask

  task automatic test_done_squash();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, i, 0, 0, 0, 0, 0, 0);
      tick();
    end
    drive(1, 0, 0, 0, 1, 2, 1, 1, 0); tick();
    idle();                            tick();
    drive(1, 1, 9, 1, 0, 0, 0, 0, 0);
    checks++; if (out_alloc_ok !== 1'b1 || out_alloc_idx !== 3'd2) begin errors++; $display("FAIL squash_realloc got ok=%0b idx=%0d want ok=1 idx=2", out_alloc_ok, out_alloc_idx); end
    tick();
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 1, 1, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    idle();
    checks++; if (out_commit_idx !== 3'd2) begin errors++; $display("FAIL squash_head got %0d want 2", out_commit_idx); end
    checks++; if (out_commit_valid !== 1'b0) begin errors++; $display("FAIL squash_done_leak got %0b want 0", out_commit_valid); end
    checks++; if (out_count !== 4'd1) begin errors++; $display("FAIL squash_count got %0d want 1", out_count); end
    $display("test_done_squash done");
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, i, 1, 0, 0, 0, 0, 0);
      tick();
    end
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0); tick();
    drive(0, 1, 7, 1, 1, 1, 1, 2, 1); tick();
    idle();
    checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL midrst_count got %0d want 0", out_count); end
    checks++; if (out_empty !== 1'b1) begin errors++; $display("FAIL midrst_empty got %0b want 1", out_empty); end
    checks++; if (out_commit_valid !== 1'b0) begin errors++; $display("FAIL midrst_commit_valid got %0b want 0", out_commit_valid); end
    checks++; if (out_alloc_idx !== 3'd0) begin errors++; $display("FAIL midrst_tail got %0d want 0", out_alloc_idx); end
    $display("test_reset_midstream done");
  endtask

  task automatic test_random();
    bit e_ok, e_cv;
    int e_cnt, e_tail, midx;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      // Bias mispredicts toward live entries so many are accepted.
      midx = (mq.size() > 0 && $urandom_range(0, 1) == 1)
             ? wrap(m_head + int'($urandom_range(0, mq.size() - 1))) : int'($urandom_range(0, N - 1));
      drive(($urandom_range(0, 79) != 0), ($urandom_range(0, 2) != 0),
            int'($urandom_range(0, (1 << GPR_IDX_SIZE) - 1)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
            ($urandom_range(0, 11) == 0), midx, int'($urandom_range(0, 1)));
      e_ok   = m_alloc_ok();
      e_cv   = m_commit_valid();
      e_cnt  = mq.size();
      e_tail = wrap(m_head + e_cnt);
      checks++; if (out_alloc_ok !== e_ok) begin errors++; $display("FAIL rnd_alloc_ok c=%0d got %0b want %0b", c, out_alloc_ok, e_ok); end
      checks++; if (out_alloc_idx !== ROB_IDX_SIZE'(e_tail)) begin errors++; $display("FAIL rnd_alloc_idx c=%0d got %0d want %0d", c, out_alloc_idx, e_tail); end
      checks++; if (out_count !== (ROB_IDX_SIZE+1)'(e_cnt)) begin errors++; $display("FAIL rnd_count c=%0d got %0d want %0d", c, out_count, e_cnt); end
      checks++; if (out_full !== (e_cnt == N) || out_empty !== (e_cnt == 0)) begin errors++; $display("FAIL rnd_full_empty c=%0d got %0b/%0b want %0b/%0b", c, out_full, out_empty, e_cnt == N, e_cnt == 0); end
      checks++; if (out_flush !== m_flush) begin errors++; $display("FAIL rnd_flush c=%0d got %0b want %0b", c, out_flush, m_flush); end
      checks++; if (out_commit_valid !== e_cv) begin errors++; $display("FAIL rnd_commit_valid c=%0d got %0b want %0b", c, out_commit_valid, e_cv); end
      if (e_cv) begin
        checks++;
        if (out_commit_idx !== ROB_IDX_SIZE'(m_head) || out_commit_gpr_idx !== mq[0].gpr ||
            out_commit_writes_gpr !== mq[0].wr) begin
          errors++;
          $display("FAIL rnd_commit_fields c=%0d got idx=%0d gpr=%0d wr=%0b want idx=%0d gpr=%0d wr=%0b",
                   c, out_commit_idx, out_commit_gpr_idx, out_commit_writes_gpr, m_head, mq[0].gpr, mq[0].wr);
        end
      end
      tick();
    end
    $display("test_random done");
  endtask

  initial begin
    idle();
    test_reset();
    test_fill();
    test_full_wrap();
    test_commit_order();
    test_mispred_flush();
    test_done_squash();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
